// File: rtl/exmem.sv
// EX/MEM pipeline latch with data-memory access FSM; optional forwarding port under EXMEM_FWD_EN.
// Latency: one cycle EX-to-MEM on load; stalls (mem_stall) while a data access waits for dhit.
module exmem (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        flush,
  input  logic [31:0] pcplus4_in,
  input  logic [31:0] aluOutport_in,
  input  logic [31:0] storeData_in,
  input  logic [4:0]  wsel_in,
  input  logic        MemToReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        JType_in,
  input  logic        RegDst_in,
  input  logic        regWEN_in,
  input  logic        PcSrc_in,
  input  logic        JReg_in,
  input  logic        halt_in,
  output logic [31:0] pcplus4_out,
  output logic [31:0] aluOutport_out,
  output logic [4:0]  wsel_out,
  output logic        MemToReg_out,
  output logic        JType_out,
  output logic        RegDst_out,
  output logic        regWEN_out,
  output logic        PcSrc_out,
  output logic        JReg_out,
  output logic        halt_out,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [31:0] pcplus4_q, pcplus4_d, alu_q, alu_d, store_q, store_d;
  logic [4:0]  wsel_q, wsel_d;
  logic        memtoreg_q, memtoreg_d, memread_q, memread_d, memwrite_q, memwrite_d;
  logic        jtype_q, jtype_d, regdst_q, regdst_d, regwen_q, regwen_d;
  logic        pcsrc_q, pcsrc_d, jreg_q, jreg_d, halt_q, halt_d;
  logic        load;

  assign mem_stall = (state_q == ACCESS) && !dhit;
  assign load      = ihit && !mem_stall && !halt_q;

  always_comb begin
    state_d    = state_q;
    pcplus4_d  = pcplus4_q;
    alu_d      = alu_q;
    store_d    = store_q;
    wsel_d     = wsel_q;
    memtoreg_d = memtoreg_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    jtype_d    = jtype_q;
    regdst_d   = regdst_q;
    regwen_d   = regwen_q;
    pcsrc_d    = pcsrc_q;
    jreg_d     = jreg_q;
    halt_d     = halt_q;
    // A stalled access freezes everything; otherwise the FSM follows what this cycle captures.
    if (!mem_stall) begin
      state_d = (load && !flush && (MemRead_in || MemWrite_in)) ? ACCESS : IDLE;
    end
    if (load) begin
      if (flush) begin
        pcplus4_d  = '0;
        alu_d      = '0;
        store_d    = '0;
        wsel_d     = '0;
        memtoreg_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        jtype_d    = 1'b0;
        regdst_d   = 1'b0;
        regwen_d   = 1'b0;
        pcsrc_d    = 1'b0;
        jreg_d     = 1'b0;
        halt_d     = 1'b0;
      end else begin
        pcplus4_d  = pcplus4_in;
        alu_d      = aluOutport_in;
        store_d    = storeData_in;
        wsel_d     = wsel_in;
        memtoreg_d = MemToReg_in;
        memread_d  = MemRead_in && !MemWrite_in;
        memwrite_d = MemWrite_in;
        jtype_d    = JType_in;
        regdst_d   = RegDst_in;
        regwen_d   = regWEN_in;
        pcsrc_d    = PcSrc_in;
        jreg_d     = JReg_in;
        halt_d     = halt_in;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      pcplus4_q  <= '0;
      alu_q      <= '0;
      store_q    <= '0;
      wsel_q     <= '0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      jtype_q    <= 1'b0;
      regdst_q   <= 1'b0;
      regwen_q   <= 1'b0;
      pcsrc_q    <= 1'b0;
      jreg_q     <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcplus4_q  <= pcplus4_d;
      alu_q      <= alu_d;
      store_q    <= store_d;
      wsel_q     <= wsel_d;
      memtoreg_q <= memtoreg_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      jtype_q    <= jtype_d;
      regdst_q   <= regdst_d;
      regwen_q   <= regwen_d;
      pcsrc_q    <= pcsrc_d;
      jreg_q     <= jreg_d;
      halt_q     <= halt_d;
    end
  end

  assign pcplus4_out    = pcplus4_q;
  assign aluOutport_out = alu_q;
  assign wsel_out       = wsel_q;
  assign MemToReg_out   = memtoreg_q;
  assign JType_out      = jtype_q;
  assign RegDst_out     = regdst_q;
  assign regWEN_out     = regwen_q;
  assign PcSrc_out      = pcsrc_q;
  assign JReg_out       = jreg_q;
  assign halt_out       = halt_q;
  assign dmemREN        = (state_q == ACCESS) && memread_q;
  assign dmemWEN        = (state_q == ACCESS) && memwrite_q;
  assign dmemaddr       = alu_q;
  assign dmemstore      = store_q;

`ifdef EXMEM_FWD_EN
  assign fwd_valid = regwen_q && (wsel_q != 5'd0) && !memtoreg_q;
  assign fwd_reg   = wsel_q;
  assign fwd_data  = jtype_q ? pcplus4_q : alu_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_exmem.sv
// Directed bench for exmem: reset, ALU pass-through, stalled load, back-to-back access, flush, forwarding, halt.
module tb_exmem;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        ihit, dhit, flush;
  logic [31:0] pcplus4_in, aluOutport_in, storeData_in;
  logic [4:0]  wsel_in;
  logic        MemToReg_in, MemRead_in, MemWrite_in, JType_in, RegDst_in, regWEN_in, PcSrc_in, JReg_in, halt_in;
  logic [31:0] pcplus4_out, aluOutport_out, dmemaddr, dmemstore, fwd_data;
  logic [4:0]  wsel_out, fwd_reg;
  logic        MemToReg_out, JType_out, RegDst_out, regWEN_out, PcSrc_out, JReg_out, halt_out;
  logic        dmemREN, dmemWEN, mem_stall, fwd_valid;
  int n_checks = 0;
  int n_fail = 0;

  exmem dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .pcplus4_in(pcplus4_in), .aluOutport_in(aluOutport_in), .storeData_in(storeData_in),
    .wsel_in(wsel_in), .MemToReg_in(MemToReg_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .JType_in(JType_in), .RegDst_in(RegDst_in), .regWEN_in(regWEN_in), .PcSrc_in(PcSrc_in),
    .JReg_in(JReg_in), .halt_in(halt_in),
    .pcplus4_out(pcplus4_out), .aluOutport_out(aluOutport_out), .wsel_out(wsel_out),
    .MemToReg_out(MemToReg_out), .JType_out(JType_out), .RegDst_out(RegDst_out),
    .regWEN_out(regWEN_out), .PcSrc_out(PcSrc_out), .JReg_out(JReg_out), .halt_out(halt_out),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    ihit = 0; dhit = 0; flush = 0;
    pcplus4_in = 0; aluOutport_in = 0; storeData_in = 0; wsel_in = 0;
    MemToReg_in = 0; MemRead_in = 0; MemWrite_in = 0; JType_in = 0; RegDst_in = 0;
    regWEN_in = 0; PcSrc_in = 0; JReg_in = 0; halt_in = 0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge CLK); nRST = 0;
    @(negedge CLK); nRST = 1;
    #1;
  endtask

  task automatic test_reset();
    logic [200:0] all_out;
    clear_inputs();
    do_reset();
    ihit = 1; dhit = 0; pcplus4_in = '1; aluOutport_in = '1; storeData_in = '1; wsel_in = '1;
    MemToReg_in = 1; MemRead_in = 1; MemWrite_in = 1; JType_in = 1; RegDst_in = 1;
    regWEN_in = 1; PcSrc_in = 1; JReg_in = 1; halt_in = 1;
    tick();
    n_checks++;
    if (dmemWEN !== 1'b1 || halt_out !== 1'b1 || aluOutport_out !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL reset_preload: wen=%b halt=%b alu=%h, required 1 1 ffffffff", dmemWEN, halt_out, aluOutport_out);
    end
    flush = 1; dhit = 1;
    @(negedge CLK); nRST = 0; #1;
    all_out = {pcplus4_out, aluOutport_out, wsel_out, MemToReg_out, JType_out, RegDst_out, regWEN_out,
               PcSrc_out, JReg_out, halt_out, dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               fwd_valid, fwd_reg, fwd_data};
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_async: outputs=%h, required all zero", all_out);
    end
    clear_inputs();
    @(negedge CLK); nRST = 1;
    tick();
    n_checks++;
    if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_req: ren=%b wen=%b stall=%b, required 0 0 0", dmemREN, dmemWEN, mem_stall);
    end
  endtask

  task automatic test_alu();
    do_reset();
    ihit = 1; aluOutport_in = 32'h0000_1234; wsel_in = 5; regWEN_in = 1;
    tick();
    n_checks++;
    if (aluOutport_out !== 32'h1234 || wsel_out !== 5'd5 || regWEN_out !== 1'b1) begin
      n_fail++; $display("FAIL alu_capture: alu=%h wsel=%0d wen=%b, required 1234 5 1", aluOutport_out, wsel_out, regWEN_out);
    end
    n_checks++;
    if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL alu_no_mem: ren=%b wen=%b stall=%b, required 0 0 0", dmemREN, dmemWEN, mem_stall);
    end
    ihit = 0; aluOutport_in = 32'h5678;
    tick();
    n_checks++;
    if (aluOutport_out !== 32'h1234) begin
      n_fail++; $display("FAIL alu_hold: alu=%h, required 1234", aluOutport_out);
    end
  endtask

  task automatic test_load_wait();
    do_reset();
    ihit = 1; MemRead_in = 1; aluOutport_in = 32'h100; wsel_in = 7; regWEN_in = 1; MemToReg_in = 1;
    tick();
    flush = 1; aluOutport_in = 32'hFFFF; wsel_in = 3; MemRead_in = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dmemREN !== 1'b1 || dmemaddr !== 32'h100 || mem_stall !== 1'b1 || wsel_out !== 5'd7) begin
        n_fail++; $display("FAIL load_wait[%0d]: ren=%b addr=%h stall=%b wsel=%0d, required 1 100 1 7", i, dmemREN, dmemaddr, mem_stall, wsel_out);
      end
      tick();
    end
    dhit = 1; flush = 0; ihit = 0; #1;
    n_checks++;
    if (mem_stall !== 1'b0 || dmemREN !== 1'b1) begin
      n_fail++; $display("FAIL load_dhit: stall=%b ren=%b, required 0 1", mem_stall, dmemREN);
    end
    tick();
    n_checks++;
    if (dmemREN !== 1'b0 || mem_stall !== 1'b0 || dmemaddr !== 32'h100) begin
      n_fail++; $display("FAIL load_done: ren=%b stall=%b addr=%h, required 0 0 100", dmemREN, mem_stall, dmemaddr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ihit = 1; MemWrite_in = 1; aluOutport_in = 32'h200; storeData_in = 32'hDEAD_BEEF;
    tick();
    n_checks++;
    if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemaddr !== 32'h200 || dmemstore !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL b2b_store: wen=%b ren=%b addr=%h data=%h, required 1 0 200 deadbeef", dmemWEN, dmemREN, dmemaddr, dmemstore);
    end
    dhit = 1; MemWrite_in = 0; MemRead_in = 1; aluOutport_in = 32'h204; storeData_in = 0;
    tick();
    n_checks++;
    if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || dmemaddr !== 32'h204) begin
      n_fail++; $display("FAIL b2b_load: ren=%b wen=%b addr=%h, required 1 0 204", dmemREN, dmemWEN, dmemaddr);
    end
    MemRead_in = 0; ihit = 0;
    tick();
    n_checks++;
    if (dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: ren=%b wen=%b, required 0 0", dmemREN, dmemWEN);
    end
  endtask

  task automatic test_write_wins();
    do_reset();
    ihit = 1; MemRead_in = 1; MemWrite_in = 1; aluOutport_in = 32'h80;
    tick();
    n_checks++;
    if (dmemWEN !== 1'b1 || dmemREN !== 1'b0) begin
      n_fail++; $display("FAIL write_wins: wen=%b ren=%b, required 1 0", dmemWEN, dmemREN);
    end
    clear_inputs(); dhit = 1;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    ihit = 1; aluOutport_in = 32'h55; wsel_in = 9; regWEN_in = 1;
    tick();
    flush = 1; MemWrite_in = 1; JType_in = 1; PcSrc_in = 1; pcplus4_in = 32'h44;
    tick();
    n_checks++;
    if ({regWEN_out, MemToReg_out, JType_out, RegDst_out, PcSrc_out, JReg_out, halt_out} !== 7'b0 ||
        wsel_out !== 5'd0 || aluOutport_out !== 32'h0 || pcplus4_out !== 32'h0) begin
      n_fail++; $display("FAIL flush_bubble: wen=%b wsel=%0d alu=%h pc4=%h, required all 0", regWEN_out, wsel_out, aluOutport_out, pcplus4_out);
    end
    n_checks++;
    if (dmemWEN !== 1'b0 || mem_stall !== 1'b0 || fwd_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_mem: wen=%b stall=%b fwd_valid=%b, required 0 0 0", dmemWEN, mem_stall, fwd_valid);
    end
  endtask

  task automatic test_fwd();
    logic        exp_v;
    logic [4:0]  exp_r;
    logic [31:0] exp_d;
    do_reset();
    ihit = 1; JType_in = 1; pcplus4_in = 32'h40; aluOutport_in = 32'h99; wsel_in = 31; regWEN_in = 1;
    tick();
`ifdef EXMEM_FWD_EN
    exp_v = 1; exp_r = 31; exp_d = 32'h40;
`else
    exp_v = 0; exp_r = 0; exp_d = 0;
`endif
    n_checks++;
    if (fwd_valid !== exp_v || fwd_reg !== exp_r || fwd_data !== exp_d) begin
      n_fail++; $display("FAIL fwd_jtype: v=%b r=%0d d=%h, required %b %0d %h", fwd_valid, fwd_reg, fwd_data, exp_v, exp_r, exp_d);
    end
    JType_in = 0; wsel_in = 12;
    tick();
`ifdef EXMEM_FWD_EN
    exp_v = 1; exp_r = 12; exp_d = 32'h99;
`endif
    n_checks++;
    if (fwd_valid !== exp_v || fwd_reg !== exp_r || fwd_data !== exp_d) begin
      n_fail++; $display("FAIL fwd_alu: v=%b r=%0d d=%h, required %b %0d %h", fwd_valid, fwd_reg, fwd_data, exp_v, exp_r, exp_d);
    end
    wsel_in = 0;
    tick();
    n_checks++;
    if (fwd_valid !== 1'b0) begin
      n_fail++; $display("FAIL fwd_r0: v=%b, required 0", fwd_valid);
    end
    wsel_in = 4; MemToReg_in = 1;
    tick();
    n_checks++;
    if (fwd_valid !== 1'b0) begin
      n_fail++; $display("FAIL fwd_memtoreg: v=%b, required 0", fwd_valid);
    end
  endtask

  task automatic test_halt();
    do_reset();
    ihit = 1; halt_in = 1; MemRead_in = 1; aluOutport_in = 32'h300;
    tick();
    n_checks++;
    if (halt_out !== 1'b1 || dmemREN !== 1'b1 || mem_stall !== 1'b1) begin
      n_fail++; $display("FAIL halt_capture: halt=%b ren=%b stall=%b, required 1 1 1", halt_out, dmemREN, mem_stall);
    end
    halt_in = 0; MemRead_in = 0; aluOutport_in = 32'h400; dhit = 1;
    tick();
    n_checks++;
    if (dmemREN !== 1'b0 || mem_stall !== 1'b0 || aluOutport_out !== 32'h300 || halt_out !== 1'b1) begin
      n_fail++; $display("FAIL halt_complete: ren=%b stall=%b alu=%h halt=%b, required 0 0 300 1", dmemREN, mem_stall, aluOutport_out, halt_out);
    end
    tick();
    n_checks++;
    if (aluOutport_out !== 32'h300 || halt_out !== 1'b1) begin
      n_fail++; $display("FAIL halt_frozen: alu=%h halt=%b, required 300 1", aluOutport_out, halt_out);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_alu();
    test_load_wait();
    test_back_to_back();
    test_write_wins();
    test_flush();
    test_fwd();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
